// File: rtl/spike_residue.sv
// Threshold-and-fire stage: compares a membrane potential against THRESHOLD,
// emitting a spike bit and the post-fire residue on two independent channels.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   L_data, L_valid, L_ready          input potential handshake
//   OutSpike_data/valid/ready         1-bit spike decision channel
//   Residue_data/valid/ready          residue potential channel
module spike_residue #(
    parameter int FILTER_WIDTH = 8,
    parameter int THRESHOLD    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FILTER_WIDTH-1:0] L_data,
    input  logic                    L_valid,
    output logic                    L_ready,
    output logic                    OutSpike_data,
    output logic                    OutSpike_valid,
    input  logic                    OutSpike_ready,
    output logic [FILTER_WIDTH-1:0] Residue_data,
    output logic                    Residue_valid,
    input  logic                    Residue_ready
);

    localparam logic [FILTER_WIDTH-1:0] TH = FILTER_WIDTH'(THRESHOLD);

    logic                    spike_free;
    logic                    residue_free;
    logic                    take;
    logic                    fire;
    logic [FILTER_WIDTH-1:0] residue_next;

    // A slot can take new data if it is empty or is draining this cycle.
    // Both slots must be free so spike and residue stay paired.
    assign spike_free   = !OutSpike_valid || OutSpike_ready;
    assign residue_free = !Residue_valid || Residue_ready;
    assign L_ready      = spike_free && residue_free;
    assign take         = L_valid && L_ready;

    // Subtraction only on the fire path, so it cannot underflow.
    assign fire         = L_data >= TH;
    assign residue_next = fire ? L_data - TH : L_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OutSpike_valid <= 1'b0;
            OutSpike_data  <= 1'b0;
        end else if (take) begin
            OutSpike_valid <= 1'b1;
            OutSpike_data  <= fire;
        end else if (OutSpike_ready) begin
            OutSpike_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Residue_valid <= 1'b0;
            Residue_data  <= '0;
        end else if (take) begin
            Residue_valid <= 1'b1;
            Residue_data  <= residue_next;
        end else if (Residue_ready) begin
            Residue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_residue.sv
// Scoreboard bench for spike_residue: random and directed stimulus,
// expected (spike, residue) pairs queued on acceptance and popped on drain.
module tb_spike_residue;

    localparam int TH = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] L_data;
    logic       L_valid;
    logic       L_ready;
    logic       OutSpike_data;
    logic       OutSpike_valid;
    logic       OutSpike_ready;
    logic [7:0] Residue_data;
    logic       Residue_valid;
    logic       Residue_ready;

    logic [3:0] s_L_data;
    logic       s_L_valid;
    logic       s_L_ready;
    logic       s_spk;
    logic       s_spk_v;
    logic       s_spk_r;
    logic [3:0] s_res;
    logic       s_res_v;
    logic       s_res_r;

    int n_chk  = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    bit stream_chk = 0;

    logic       sq[$];
    logic [7:0] rq[$];

    bit         sp_hold = 0;
    bit         rs_hold = 0;
    logic       sp_prev;
    logic [7:0] rs_prev;

    always #5 clk = ~clk;

    spike_residue #(.FILTER_WIDTH(8), .THRESHOLD(TH)) dut (
        .clk            (clk),
        .rst            (rst),
        .L_data         (L_data),
        .L_valid        (L_valid),
        .L_ready        (L_ready),
        .OutSpike_data  (OutSpike_data),
        .OutSpike_valid (OutSpike_valid),
        .OutSpike_ready (OutSpike_ready),
        .Residue_data   (Residue_data),
        .Residue_valid  (Residue_valid),
        .Residue_ready  (Residue_ready)
    );

    spike_residue #(.FILTER_WIDTH(4), .THRESHOLD(15)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .L_data         (s_L_data),
        .L_valid        (s_L_valid),
        .L_ready        (s_L_ready),
        .OutSpike_data  (s_spk),
        .OutSpike_valid (s_spk_v),
        .OutSpike_ready (s_spk_r),
        .Residue_data   (s_res),
        .Residue_valid  (s_res_v),
        .Residue_ready  (s_res_r)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: fire when potential reaches threshold, subtract on fire.
    function automatic int ref_spike(input int d);
        return (d >= TH) ? 1 : 0;
    endfunction

    function automatic int ref_res(input int d);
        return (d >= TH) ? d - TH : d;
    endfunction

    // Monitor: inputs change just after posedge, so at negedge the
    // handshakes for the coming edge are settled.
    always @(negedge clk) begin
        if (rst) begin
            sq.delete();
            rq.delete();
            sp_hold = 0;
            rs_hold = 0;
        end else begin
            if (sp_hold) begin
                chk("spike_hold_valid", int'(OutSpike_valid), 1);
                chk("spike_hold_data", int'(OutSpike_data), int'(sp_prev));
            end
            if (rs_hold) begin
                chk("res_hold_valid", int'(Residue_valid), 1);
                chk("res_hold_data", int'(Residue_data), int'(rs_prev));
            end
            sp_hold = OutSpike_valid && !OutSpike_ready;
            sp_prev = OutSpike_data;
            rs_hold = Residue_valid && !Residue_ready;
            rs_prev = Residue_data;

            if (OutSpike_valid && OutSpike_ready) begin
                if (sq.size() == 0) begin
                    chk("spike_unexpected", 1, 0);
                end else begin
                    chk("spike_data", int'(OutSpike_data), int'(sq.pop_front()));
                end
            end
            if (Residue_valid && Residue_ready) begin
                if (rq.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    chk("res_data", int'(Residue_data), int'(rq.pop_front()));
                end
            end
            if (L_valid && L_ready) begin
                sq.push_back(1'(ref_spike(int'(L_data))));
                rq.push_back(8'(ref_res(int'(L_data))));
                acc_cnt++;
            end
            if (stream_chk) chk("stream_l_ready", int'(L_ready), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bvals[5];
        int bspk[5];
        int bres[5];
        int cyc;
        int target;

        bvals = '{0, 63, 64, 65, 255};
        bspk  = '{0, 0, 1, 1, 1};
        bres  = '{0, 63, 0, 1, 191};

        rst = 1;
        L_data = 0;
        L_valid = 0;
        OutSpike_ready = 0;
        Residue_ready = 0;
        s_L_data = 0;
        s_L_valid = 0;
        s_spk_r = 1;
        s_res_r = 1;

        step();
        step();
        chk("rst_spike_valid", int'(OutSpike_valid), 0);
        chk("rst_res_valid", int'(Residue_valid), 0);
        chk("rst_spike_data", int'(OutSpike_data), 0);
        chk("rst_res_data", int'(Residue_data), 0);
        rst = 0;
        step();
        chk("rst_l_ready", int'(L_ready), 1);

        // Threshold boundaries
        OutSpike_ready = 1;
        Residue_ready = 1;
        for (int i = 0; i < 5; i++) begin
            L_valid = 1;
            L_data = 8'(bvals[i]);
            step();
            chk("bnd_spike_valid", int'(OutSpike_valid), 1);
            chk("bnd_spike", int'(OutSpike_data), bspk[i]);
            chk("bnd_res_valid", int'(Residue_valid), 1);
            chk("bnd_res", int'(Residue_data), bres[i]);
        end
        L_valid = 0;
        step();

        // Back-to-back streaming
        for (int i = 0; i < 100; i++) begin
            L_valid = 1;
            L_data = 8'($urandom);
            stream_chk = 1;
            step();
        end
        stream_chk = 0;
        L_valid = 0;
        step();
        step();

        // Split backpressure
        OutSpike_ready = 0;
        Residue_ready = 1;
        L_valid = 1;
        L_data = 100;
        step();
        chk("split_spike_valid", int'(OutSpike_valid), 1);
        chk("split_spike", int'(OutSpike_data), 1);
        chk("split_res_valid", int'(Residue_valid), 1);
        chk("split_res", int'(Residue_data), 36);
        L_data = 7;
        chk("split_l_ready", int'(L_ready), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("split_res_drained", int'(Residue_valid), 0);
            chk("split_l_ready", int'(L_ready), 0);
            chk("split_spike_held", int'(OutSpike_data), 1);
        end
        OutSpike_ready = 1;
        #1;
        chk("split_release_ready", int'(L_ready), 1);
        step();
        chk("split_next_spike", int'(OutSpike_data), 0);
        chk("split_next_res", int'(Residue_data), 7);
        L_valid = 0;
        step();

        // Random ready/valid toggling
        target = acc_cnt + 1000;
        cyc = 0;
        while (acc_cnt < target && cyc < 20000) begin
            L_valid = 1'($urandom);
            L_data = 8'($urandom);
            OutSpike_ready = 1'($urandom);
            Residue_ready = 1'($urandom);
            step();
            cyc++;
        end
        chk("random_budget", int'(acc_cnt >= target), 1);
        L_valid = 0;
        OutSpike_ready = 1;
        Residue_ready = 1;
        cyc = 0;
        while ((sq.size() != 0 || rq.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        chk("drain_spike_q", sq.size(), 0);
        chk("drain_res_q", rq.size(), 0);

        // Reset mid-transfer
        OutSpike_ready = 0;
        Residue_ready = 0;
        L_valid = 1;
        L_data = 90;
        step();
        L_valid = 0;
        step();
        chk("pre_rst_spike_valid", int'(OutSpike_valid), 1);
        chk("pre_rst_res_valid", int'(Residue_valid), 1);
        #1;
        rst = 1;
        #1;
        chk("mid_rst_spike_valid", int'(OutSpike_valid), 0);
        chk("mid_rst_res_valid", int'(Residue_valid), 0);
        chk("mid_rst_spike_data", int'(OutSpike_data), 0);
        chk("mid_rst_res_data", int'(Residue_data), 0);
        step();
        rst = 0;
        OutSpike_ready = 1;
        Residue_ready = 1;
        L_valid = 1;
        L_data = 200;
        step();
        L_valid = 0;
        chk("post_rst_spike", int'(OutSpike_data), 1);
        chk("post_rst_res", int'(Residue_data), 136);
        chk("post_rst_valid", int'(OutSpike_valid && Residue_valid), 1);
        step();

        // Narrow instance: FILTER_WIDTH=4, THRESHOLD=15
        s_L_valid = 1;
        s_L_data = 15;
        step();
        chk("w4_15_spike", int'(s_spk), 1);
        chk("w4_15_res", int'(s_res), 0);
        s_L_data = 14;
        step();
        chk("w4_14_spike", int'(s_spk), 0);
        chk("w4_14_res", int'(s_res), 14);
        s_L_data = 0;
        step();
        chk("w4_0_spike", int'(s_spk), 0);
        chk("w4_0_res", int'(s_res), 0);
        s_L_valid = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
